// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: shares one single-port data memory between the core MEM stage
// and an auxiliary requester (program loader / debug). Each access is a req/ack
// handshake against variable-latency memory; core_stall freezes the pipeline until
// the core access completes.
//
// Optional feature: define DMEM_ARB_STARVE_EN to build the aux starvation counter.
// When the macro is undefined the core has strict priority and aux may starve.
module dmem_arbiter #(
  parameter int unsigned AW           = 32,
  parameter int unsigned DW           = 32,
  parameter int unsigned AUX_MAX_WAIT = 8
) (
  input  logic            clk,
  input  logic            reset,
  // Core MEM stage (fed from EX/MEM pipeline register outputs)
  input  logic            core_req,
  input  logic            core_we,
  input  logic [AW-1:0]   core_addr,
  input  logic [DW-1:0]   core_wdata,
  input  logic [DW/8-1:0] core_be,
  output logic [DW-1:0]   core_rdata,
  output logic            core_stall,
  // Auxiliary requester
  input  logic            aux_valid,
  input  logic            aux_we,
  input  logic [AW-1:0]   aux_addr,
  input  logic [DW-1:0]   aux_wdata,
  output logic            aux_ready,
  output logic [DW-1:0]   aux_rdata,
  // Memory side
  output logic            mem_req,
  output logic            mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  output logic [DW/8-1:0] mem_be,
  input  logic            mem_ack,
  input  logic [DW-1:0]   mem_rdata
);

  // The wait counter is 8 bits wide, so the threshold must fit in it.
  if (AUX_MAX_WAIT < 1 || AUX_MAX_WAIT > 255) begin : g_bad_aux_max_wait
    $error("dmem_arbiter: AUX_MAX_WAIT must be in 1..255");
  end

  typedef enum logic [1:0] {
    StIdle,
    StCore,
    StAux
  } state_e;

  state_e state_q, state_d;

  // Completion strobes for the current owner.
  logic core_done;
  logic aux_done;
  // Aux has waited long enough to override core priority.
  logic aux_force;

  assign core_done = (state_q == StCore) && mem_ack;
  assign aux_done  = (state_q == StAux) && mem_ack;

`ifdef DMEM_ARB_STARVE_EN
  localparam logic [7:0] MaxWait = 8'(AUX_MAX_WAIT);

  logic [7:0] wait_q, wait_d;

  assign aux_force = aux_valid && (wait_q == MaxWait);

  // Starvation counter: counts cycles aux waits outside AUX, saturates, clears on grant.
  always_comb begin
    wait_d = wait_q;
    if (state_q == StIdle && state_d == StAux) begin
      wait_d = 8'd0;
    end else if (aux_valid && state_q != StAux && wait_q != MaxWait) begin
      wait_d = wait_q + 8'd1;
    end
  end

  // Starvation counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_q <= 8'd0;
    end else begin
      wait_q <= wait_d;
    end
  end
`else
  assign aux_force = 1'b0;
`endif

  // Next-state: grants only from IDLE, so every access is separated by an IDLE cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (aux_force) begin
          state_d = StAux;
        end else if (core_req) begin
          state_d = StCore;
        end else if (aux_valid) begin
          state_d = StAux;
        end
      end
      StCore: begin
        // A flushed core access (core_req dropped) still runs to mem_ack.
        if (mem_ack) begin
          state_d = StIdle;
        end
      end
      StAux: begin
        if (mem_ack) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State register; asynchronous reset drops mem_req in the same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Memory-side mux from the current owner; all fields zero while idle.
  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_be    = '0;
    case (state_q)
      StCore: begin
        mem_req   = 1'b1;
        mem_we    = core_we;
        mem_addr  = core_addr;
        mem_wdata = core_wdata;
        mem_be    = core_be;
      end
      StAux: begin
        mem_req   = 1'b1;
        mem_we    = aux_we;
        mem_addr  = aux_addr;
        mem_wdata = aux_wdata;
        mem_be    = '1;
      end
      default: begin
        mem_req = 1'b0;
      end
    endcase
  end

  // Requester-side responses; read data is gated to zero outside the completion cycle.
  always_comb begin
    core_stall = core_req & ~core_done;
    core_rdata = core_done ? mem_rdata : '0;
    aux_ready  = aux_done;
    aux_rdata  = aux_done ? mem_rdata : '0;
  end

endmodule
